// File: rtl/dmem_bridge.sv
// dmem_bridge: a single-access bridge from the M-stage load/store request to
// an SRAM-like data bus that uses req/addr_ok/data_ok handshakes.
// The bridge latches one access and drives it onto the bus. It stalls the
// pipeline until the access completes. After that it holds the load result
// in DONE for as long as some other stall source keeps the pipeline frozen.
//
// Optional build macro: DMEM_ADDR_MAP_EN
//   When defined, addresses in the 0x8000_0000-0xBFFF_FFFF window
//   (kseg0/kseg1) are mapped to physical addresses by clearing the top three
//   bits. All other addresses pass through unchanged.
//   When undefined, the latched address is driven onto the bus verbatim.

module dmem_bridge #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,

  // M-stage request side
  input  logic          cpu_en,
  input  logic [3:0]    cpu_wen,
  input  logic [1:0]    cpu_size,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          other_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,

  // SRAM-like data bus side
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [3:0]    data_wstrb,
  output logic [AW-1:0] data_addr,
  output logic [DW-1:0] data_wdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [DW-1:0] data_rdata
);

  // IDLE : waiting for an M-stage memory instruction
  // ADDR : request on the bus, waiting for the slave to accept it
  // DATA : request accepted, waiting for read data or the write ack
  // DONE : access finished, waiting for the pipeline to advance
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    DONE = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    wen_q,   wen_d;
  logic [1:0]    size_q,  size_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          isLoad;

  // A latched write-enable of all zeros marks the access as a load.
  assign isLoad = (wen_q == 4'b0000);

  // Compute the next state and the next values of the latched access and
  // the read-data registers. Each register holds its value unless a
  // transition below updates it.
  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (cpu_en) begin
          wen_d   = cpu_wen;
          size_d  = cpu_size;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = ADDR;
        end
      end

      ADDR: begin
        // data_data_ok only counts here when it arrives together with
        // addr_ok (a zero-latency slave). On its own it is ignored.
        if (data_addr_ok) begin
          if (data_data_ok) begin
            rdata_d = data_rdata;
            state_d = DONE;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (data_data_ok) begin
          if (isLoad) begin
            rdata_d = data_rdata;
          end
          state_d = DONE;
        end
      end

      DONE: begin
        // The pipeline advances on the edge that leaves DONE. Returning to
        // IDLE therefore never picks the same instruction up a second time.
        if (!other_stall) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registers for the state and the latched access. All are cleared
  // asynchronously when rst goes low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wen_q   <= '0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // The request is valid only in ADDR. Every other bus field comes straight
  // from a latched register, so the fields stay stable while req is high.
  assign data_req   = (state_q == ADDR);
  assign data_wr    = |wen_q;
  assign data_wstrb = wen_q;
  assign data_size  = size_q;
  assign data_wdata = wdata_q;

`ifdef DMEM_ADDR_MAP_EN
  // Map kseg0/kseg1 virtual addresses to physical addresses by clearing
  // the top three bits. Any other address passes through unchanged.
  always_comb begin
    data_addr = addr_q;
    if (addr_q[AW-1:AW-2] == 2'b10) begin
      data_addr = {3'b000, addr_q[AW-4:0]};
    end
  end
`else
  assign data_addr = addr_q;
`endif

  // The stall drops in DONE, so the pipeline advances on the edge that
  // leaves DONE. The raw captured word goes back to the M stage.
  assign cpu_stall = cpu_en & (state_q != DONE);
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed, self-checking bench for dmem_bridge.
// The bench plays the slave by hand, cycle by cycle. Expected values are
// written as constants next to each step.

module tb_dmem_bridge;

  logic        clock;
  logic        resetN;
  logic        cpuEn;
  logic [3:0]  cpuWen;
  logic [1:0]  cpuSize;
  logic [31:0] cpuAddr;
  logic [31:0] cpuWdata;
  logic        otherStall;
  logic [31:0] cpuRdata;
  logic        cpuStall;
  logic        dataReq;
  logic        dataWr;
  logic [1:0]  dataSize;
  logic [3:0]  dataWstrb;
  logic [31:0] dataAddr;
  logic [31:0] dataWdata;
  logic        dataAddrOk;
  logic        dataDataOk;
  logic [31:0] dataRdata;

  int checkCount = 0;
  int passCount  = 0;

  dmem_bridge #(.AW(32), .DW(32)) dut (
    .clk          (clock),
    .rst          (resetN),
    .cpu_en       (cpuEn),
    .cpu_wen      (cpuWen),
    .cpu_size     (cpuSize),
    .cpu_addr     (cpuAddr),
    .cpu_wdata    (cpuWdata),
    .other_stall  (otherStall),
    .cpu_rdata    (cpuRdata),
    .cpu_stall    (cpuStall),
    .data_req     (dataReq),
    .data_wr      (dataWr),
    .data_size    (dataSize),
    .data_wstrb   (dataWstrb),
    .data_addr    (dataAddr),
    .data_wdata   (dataWdata),
    .data_addr_ok (dataAddrOk),
    .data_data_ok (dataDataOk),
    .data_rdata   (dataRdata)
  );

  // 10 ns clock period
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance to 2 ns after the next rising edge, where new inputs are driven.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Drive the M-stage request inputs.
  task automatic applyStimulus(input logic en, input logic [3:0] wen,
                               input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata);
    cpuEn    = en;
    cpuWen   = wen;
    cpuSize  = size;
    cpuAddr  = addr;
    cpuWdata = wdata;
  endtask

  // Drive the slave handshake inputs.
  task automatic slave(input logic addrOk, input logic dataOk,
                       input logic [31:0] rdata);
    dataAddrOk = addrOk;
    dataDataOk = dataOk;
    dataRdata  = rdata;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  logic [31:0] mappedAddr;

  initial begin
`ifdef DMEM_ADDR_MAP_EN
    mappedAddr = 32'h1FC0_0100;
`else
    mappedAddr = 32'hBFC0_0100;
`endif
    applyStimulus(1'b0, 4'h0, 2'b00, 32'h0, 32'h0);
    slave(1'b0, 1'b0, 32'h0);
    otherStall = 1'b0;
    resetN     = 1'b0;

    // ---- reset state ----
    #3;
    checkOutput("rst_req",   {31'b0, dataReq},   32'd0);
    checkOutput("rst_wr",    {31'b0, dataWr},    32'd0);
    checkOutput("rst_size",  {30'b0, dataSize},  32'd0);
    checkOutput("rst_wstrb", {28'b0, dataWstrb}, 32'd0);
    checkOutput("rst_addr",  dataAddr,           32'd0);
    checkOutput("rst_wdata", dataWdata,          32'd0);
    checkOutput("rst_rdata", cpuRdata,           32'd0);
    checkOutput("rst_stall", {31'b0, cpuStall},  32'd0);
    tick();
    resetN = 1'b1;
    tick();

    // ---- load word, addr_ok at once, data_ok one cycle later ----
    applyStimulus(1'b1, 4'h0, 2'b10, 32'h0000_0010, 32'h0);
    #1;
    checkOutput("lw_idle_stall", {31'b0, cpuStall}, 32'd1);
    checkOutput("lw_idle_req",   {31'b0, dataReq},  32'd0);
    tick();
    slave(1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("lw_addr_req",   {31'b0, dataReq},  32'd1);
    checkOutput("lw_addr_wr",    {31'b0, dataWr},   32'd0);
    checkOutput("lw_addr_size",  {30'b0, dataSize}, 32'd2);
    checkOutput("lw_addr_addr",  dataAddr,          32'h0000_0010);
    checkOutput("lw_addr_stall", {31'b0, cpuStall}, 32'd1);
    tick();
    slave(1'b0, 1'b1, 32'hDEAD_BEEF);
    #1;
    checkOutput("lw_data_req",   {31'b0, dataReq},  32'd0);
    checkOutput("lw_data_stall", {31'b0, cpuStall}, 32'd1);
    tick();
    slave(1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("lw_done_stall", {31'b0, cpuStall}, 32'd0);
    checkOutput("lw_done_rdata", cpuRdata,          32'hDEAD_BEEF);
    checkOutput("lw_done_req",   {31'b0, dataReq},  32'd0);
    tick();
    applyStimulus(1'b0, 4'h0, 2'b00, 32'h0, 32'h0);
    tick();

    // ---- store byte, addr_ok held off for 3 cycles ----
    applyStimulus(1'b1, 4'b0100, 2'b00, 32'h0000_0022, 32'h00AB_0000);
    tick();
    for (int i = 0; i < 4; i++) begin
      slave((i == 3), 1'b0, 32'h0);
      #1;
      checkOutput("sb_req",   {31'b0, dataReq},   32'd1);
      checkOutput("sb_addr",  dataAddr,           32'h0000_0022);
      checkOutput("sb_wstrb", {28'b0, dataWstrb}, 32'h4);
      checkOutput("sb_wr",    {31'b0, dataWr},    32'd1);
      checkOutput("sb_size",  {30'b0, dataSize},  32'd0);
      checkOutput("sb_wdata", dataWdata,          32'h00AB_0000);
      checkOutput("sb_stall", {31'b0, cpuStall},  32'd1);
      tick();
    end
    slave(1'b0, 1'b1, 32'hFFFF_FFFF);
    #1;
    checkOutput("sb_data_req",   {31'b0, dataReq},  32'd0);
    checkOutput("sb_data_stall", {31'b0, cpuStall}, 32'd1);
    tick();
    slave(1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("sb_done_stall", {31'b0, cpuStall}, 32'd0);
    checkOutput("sb_keep_rdata", cpuRdata,          32'hDEAD_BEEF);
    tick();
    applyStimulus(1'b0, 4'h0, 2'b00, 32'h0, 32'h0);
    tick();

    // ---- load held in DONE by other_stall for 4 cycles ----
    applyStimulus(1'b1, 4'h0, 2'b10, 32'h0000_0040, 32'h0);
    tick();
    slave(1'b1, 1'b0, 32'h0);
    tick();
    slave(1'b0, 1'b1, 32'hCAFE_F00D);
    tick();
    otherStall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      // stray data_ok and changing rdata in DONE must be ignored
      slave(1'b0, (i == 1), 32'h1111_0000 + i);
      #1;
      checkOutput("os_stall", {31'b0, cpuStall}, 32'd0);
      checkOutput("os_req",   {31'b0, dataReq},  32'd0);
      checkOutput("os_rdata", cpuRdata,          32'hCAFE_F00D);
      tick();
    end
    slave(1'b0, 1'b0, 32'h0);
    otherStall = 1'b0;
    #1;
    checkOutput("os_release_stall", {31'b0, cpuStall}, 32'd0);
    tick();
    applyStimulus(1'b0, 4'h0, 2'b00, 32'h0, 32'h0);
    #1;
    checkOutput("os_idle_req", {31'b0, dataReq}, 32'd0);
    tick();
    checkOutput("os_no_reissue", {31'b0, dataReq}, 32'd0);
    checkOutput("os_idle_rdata", cpuRdata,         32'hCAFE_F00D);

    // ---- stray data_ok in IDLE is ignored ----
    slave(1'b0, 1'b1, 32'h7777_7777);
    tick();
    slave(1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("idle_dok_req",   {31'b0, dataReq}, 32'd0);
    checkOutput("idle_dok_rdata", cpuRdata,         32'hCAFE_F00D);
    tick();

    // ---- same-cycle addr_ok and data_ok ----
    applyStimulus(1'b1, 4'h0, 2'b10, 32'h0000_0080, 32'h0);
    tick();
    slave(1'b1, 1'b1, 32'h1234_5678);
    #1;
    checkOutput("sc_addr_req", {31'b0, dataReq}, 32'd1);
    tick();
    slave(1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("sc_done_stall", {31'b0, cpuStall}, 32'd0);
    checkOutput("sc_done_req",   {31'b0, dataReq},  32'd0);
    checkOutput("sc_rdata",      cpuRdata,          32'h1234_5678);
    tick();
    applyStimulus(1'b0, 4'h0, 2'b00, 32'h0, 32'h0);
    tick();

    // ---- reset asserted while in DATA ----
    applyStimulus(1'b1, 4'b1111, 2'b10, 32'h0000_0100, 32'hA5A5_A5A5);
    tick();
    slave(1'b1, 1'b0, 32'h0);
    tick();
    slave(1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("rd_pre_stall", {31'b0, cpuStall}, 32'd1);
    applyStimulus(1'b0, 4'h0, 2'b00, 32'h0, 32'h0);
    resetN = 1'b0;
    #1;
    checkOutput("rd_req",   {31'b0, dataReq},   32'd0);
    checkOutput("rd_wr",    {31'b0, dataWr},    32'd0);
    checkOutput("rd_wstrb", {28'b0, dataWstrb}, 32'd0);
    checkOutput("rd_size",  {30'b0, dataSize},  32'd0);
    checkOutput("rd_addr",  dataAddr,           32'd0);
    checkOutput("rd_wdata", dataWdata,          32'd0);
    checkOutput("rd_rdata", cpuRdata,           32'd0);
    checkOutput("rd_stall", {31'b0, cpuStall},  32'd0);
    tick();
    resetN = 1'b1;
    tick();
    applyStimulus(1'b1, 4'h0, 2'b10, 32'h0000_0104, 32'h0);
    #1;
    checkOutput("rd_fresh_idle_req", {31'b0, dataReq}, 32'd0);
    tick();
    slave(1'b1, 1'b1, 32'h55AA_55AA);
    #1;
    checkOutput("rd_fresh_req",  {31'b0, dataReq}, 32'd1);
    checkOutput("rd_fresh_addr", dataAddr,         32'h0000_0104);
    tick();
    slave(1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("rd_fresh_rdata", cpuRdata, 32'h55AA_55AA);
    tick();
    applyStimulus(1'b0, 4'h0, 2'b00, 32'h0, 32'h0);
    tick();

    // ---- address mapping: kseg address, then a plain low address ----
    applyStimulus(1'b1, 4'h0, 2'b10, 32'hBFC0_0100, 32'h0);
    tick();
    slave(1'b1, 1'b1, 32'h0BAD_F00D);
    #1;
    checkOutput("map_kseg_addr", dataAddr, mappedAddr);
    tick();
    slave(1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 4'h0, 2'b00, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, 4'h0, 2'b10, 32'h0000_0100, 32'h0);
    tick();
    slave(1'b1, 1'b1, 32'h0);
    #1;
    checkOutput("map_low_addr", dataAddr, 32'h0000_0100);
    tick();
    slave(1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 4'h0, 2'b00, 32'h0, 32'h0);
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
